// File: rtl/fifo_sync_level.sv
// rtl/fifo_sync_level.sv - synchronous FIFO with occupancy count and level flags
// Optional macro FIFO_SYNC_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module fifo_sync_level #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int AF_LEVEL   = 3,
  parameter int AE_LEVEL   = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr,
  input  logic                            rd,
  input  logic [DATA_WIDTH-1:0]           data_in,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            empty,
  output logic                            full,
  output logic                            almost_empty,
  output logic                            almost_full,
`ifdef FIFO_SYNC_ERR_FLAGS_EN
  output logic                            overflow,
  output logic                            underflow,
`endif
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // A write into a full FIFO is still taken when a read frees a slot on the same edge
  assign wr_acc = wr & (~full | rd);
  assign rd_acc = rd & ~empty;

  // Flags decode the registered count, so they always describe post-edge state
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);

  // Storage array; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and registered read data
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      if (wr_acc && !rd_acc) begin
        count <= count + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef FIFO_SYNC_ERR_FLAGS_EN
  // Sticky records of dropped accesses, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full && !rd) begin
        overflow <= 1'b1;
      end
      if (rd && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_level.sv
// tb/tb_fifo_sync_level.sv - directed self-checking bench for fifo_sync_level
module tb_fifo_sync_level;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr;
  logic       rd;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic [2:0] count;
`ifdef FIFO_SYNC_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  int checks = 0;
  int errors = 0;

  fifo_sync_level #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(4),
    .AF_LEVEL(3),
    .AE_LEVEL(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr(wr),
    .rd(rd),
    .data_in(data_in),
    .data_out(data_out),
    .empty(empty),
    .full(full),
    .almost_empty(almost_empty),
    .almost_full(almost_full),
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    .overflow(overflow),
    .underflow(underflow),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr = 1'b1; rd = 1'b0; data_in = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr = 1'b0; rd = 1'b0; data_in = 8'h00;
    tick();
    reset = 1'b0;
    checks++;
    if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_flags got e/f/ae/af=%b expected 1010", {empty, full, almost_empty, almost_full});
    end
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL reset_count got %0d expected 0", count);
    end
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got %0d expected 0", data_out);
    end
  endtask

  task automatic test_fill();
    logic [2:0] exp_cnt [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [2:0] exp_flg [4] = '{3'b100, 3'b000, 3'b010, 3'b011};
    for (int i = 0; i < 4; i++) begin
      push(8'(i));
      checks++;
      if (count !== exp_cnt[i]) begin
        errors++;
        $display("FAIL fill_count[%0d] got %0d expected %0d", i, count, exp_cnt[i]);
      end
      checks++;
      if ({almost_empty, almost_full, full} !== exp_flg[i]) begin
        errors++;
        $display("FAIL fill_flags[%0d] got ae/af/f=%b expected %b", i, {almost_empty, almost_full, full}, exp_flg[i]);
      end
    end
  endtask

  task automatic test_overflow_drain();
    push(8'd4);
    checks++;
    if (count !== 3'd4 || full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_count got count=%0d full=%b expected 4/1", count, full);
    end
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag got %b expected 1", overflow);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      rd = 1'b1;
      tick();
      rd = 1'b0;
      checks++;
      if (data_out !== 8'(i) || count !== 3'(3 - i)) begin
        errors++;
        $display("FAIL drain[%0d] got data=%0d count=%0d expected %0d/%0d", i, data_out, count, i, 3 - i);
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty got %b expected 1", empty);
    end
  endtask

  task automatic test_underflow();
    rd = 1'b1;
    tick();
    tick();
    rd = 1'b0;
    checks++;
    if (data_out !== 8'd3 || count !== 3'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow_hold got data=%0d count=%0d empty=%b expected 3/0/1", data_out, count, empty);
    end
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow_flag got %b expected 1", underflow);
    end
`endif
  endtask

  task automatic test_full_rw();
    logic [7:0] exp_d [4] = '{8'd1, 8'd2, 8'd3, 8'd9};
    for (int i = 0; i < 4; i++) push(8'(i));
    wr = 1'b1; rd = 1'b1; data_in = 8'd9;
    tick();
    wr = 1'b0; rd = 1'b0;
    checks++;
    if (data_out !== 8'd0 || count !== 3'd4 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_rw got data=%0d count=%0d full=%b expected 0/4/1", data_out, count, full);
    end
    for (int i = 0; i < 4; i++) begin
      rd = 1'b1;
      tick();
      rd = 1'b0;
      checks++;
      if (data_out !== exp_d[i]) begin
        errors++;
        $display("FAIL wrap_drain[%0d] got %0d expected %0d", i, data_out, exp_d[i]);
      end
    end
  endtask

  task automatic test_empty_rw();
    wr = 1'b1; rd = 1'b1; data_in = 8'd7;
    tick();
    wr = 1'b0; rd = 1'b0;
    checks++;
    if (count !== 3'd1 || data_out !== 8'd9) begin
      errors++;
      $display("FAIL empty_rw got count=%0d data=%0d expected 1/9", count, data_out);
    end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    checks++;
    if (data_out !== 8'd7 || count !== 3'd0) begin
      errors++;
      $display("FAIL empty_rw_read got data=%0d count=%0d expected 7/0", data_out, count);
    end
  endtask

  task automatic test_mid_reset();
    push(8'd10);
    push(8'd11);
    push(8'd12);
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL mid_pre_count got %0d expected 3", count);
    end
    reset = 1'b1; wr = 1'b1; data_in = 8'd13;
    tick();
    reset = 1'b0; wr = 1'b0;
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || data_out !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset got count=%0d empty=%b data=%0d expected 0/1/0", count, empty, data_out);
    end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    checks++;
    if (data_out !== 8'd0 || count !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_read got data=%0d count=%0d expected 0/0", data_out, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_underflow();
    test_full_rw();
    test_empty_rw();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
